// File: rtl/stack_cpu_pkg.sv
// Shared types and constants for the stack_cpu zero-address machine.
package stack_cpu_pkg;

   localparam int WORD_W  = 32;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int IMM_W   = 27;

   typedef enum logic [4:0] {
      OP_NOP   = 5'd0,
      OP_PUSH  = 5'd1,
      OP_POP   = 5'd2,
      OP_DUP   = 5'd3,
      OP_SWAP  = 5'd4,
      OP_ADD   = 5'd5,
      OP_JMP   = 5'd6,
      OP_SUB   = 5'd7,
      OP_AND   = 5'd8,
      OP_BRZ   = 5'd9,
      OP_STORE = 5'd10,
      OP_LOAD  = 5'd11,
      OP_OR    = 5'd12,
      OP_XOR   = 5'd13,
      OP_NOT   = 5'd14,
      OP_HALT  = 5'd15,
      OP_NEG   = 5'd16
   } opcode_e;

   typedef enum logic [2:0] {
      ST_WAIT   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // Number of entries an opcode consumes from the stack.
   function automatic logic [1:0] f_pops(input logic [4:0] op);
      case (op)
         OP_POP, OP_DUP, OP_JMP, OP_LOAD, OP_NOT, OP_NEG:              return 2'd1;
         OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BRZ,
         OP_STORE:                                                     return 2'd2;
         default:                                                      return 2'd0;
      endcase
   endfunction

   // Number of entries an opcode leaves on the stack after its pops.
   function automatic logic [1:0] f_pushes(input logic [4:0] op);
      case (op)
         OP_DUP, OP_SWAP:                                              return 2'd2;
         OP_PUSH, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD,
         OP_NOT, OP_NEG:                                               return 2'd1;
         default:                                                      return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/stack_cpu_ram.sv
// Data memory: byte-enabled synchronous write, registered read-first output.
module ram
   import stack_cpu_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_dout;
   logic [WIDTH-1:0] w_wdata;
   logic [AW-1:0]    w_idx;
   logic             w_unused_addr;

   assign w_idx         = addr[AW-1:0];
   assign w_unused_addr = ^addr[WIDTH-1:AW];
   assign dout          = r_dout;

   // Merge enabled bytes of din into the currently stored word.
   always_comb begin
      w_wdata = r_mem[w_idx];
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            w_wdata[8*i +: 8] = din[8*i +: 8];
         end else begin
            w_wdata[8*i +: 8] = r_mem[w_idx][8*i +: 8];
         end
      end
   end

   // Read the old word and commit the merged word on the same edge.
   always_ff @(posedge clk) begin
      r_dout <= r_mem[w_idx];
      if (we != 4'h0) begin
         r_mem[w_idx] <= w_wdata;
      end
   end

endmodule

// File: rtl/stack_cpu.sv
// Zero-address stack machine: one instruction per handshake, WAIT->DECODE->EXEC(->MEM)->WAIT.
module stack_cpu
   import stack_cpu_pkg::*;
#(
   parameter int CPU_BIT_WIDTH = WORD_W,
   parameter int STACK_DEPTH   = 16,
   parameter int DMEM_DEPTH    = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CPU_BIT_WIDTH-1:0] inst,
   input  logic                     inst_ready,
   output logic                     inst_complete,
   output logic [CPU_BIT_WIDTH-1:0] pc_next,
   output logic [CPU_BIT_WIDTH-1:0] tos,
   output logic                     halted,
   output logic                     error
);
   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;
   localparam int SPX_W = SP_W + 1;

   state_e                   r_state, w_state_next;
   logic [CPU_BIT_WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [SP_W-1:0]          r_sp;
   logic [CPU_BIT_WIDTH-1:0] r_inst, r_pc, r_tos;
   logic                     r_ready_d, r_complete, r_halted, r_error;

   logic [4:0]               w_op;
   logic [CPU_BIT_WIDTH-1:0] w_imm, w_a, w_b, w_c, w_alu, w_pc_inc, w_ram_dout;
   logic [CPU_BIT_WIDTH-1:0] w_tos_pop1, w_tos_pop2;
   logic [IDX_W-1:0]         w_i0, w_i1, w_i2, w_i3;
   logic [1:0]               w_pops, w_pushes;
   logic [SPX_W-1:0]         w_after;
   logic                     w_accept, w_underflow, w_overflow, w_err, w_mem_op;
   logic [3:0]               w_ram_we;

   assign w_op     = r_inst[OPC_MSB:OPC_LSB];
   assign w_imm    = CPU_BIT_WIDTH'(r_inst[IMM_W-1:0]);
   assign w_accept = (r_state == ST_WAIT) && inst_ready && !r_ready_d;
   assign w_mem_op = (w_op == OP_LOAD) || (w_op == OP_STORE);
   assign w_pc_inc = r_pc + CPU_BIT_WIDTH'(1);

   // Stack slots: i0 is the next free slot, i1 the top (b), i2 below it (a), i3 below that.
   assign w_i0 = r_sp[IDX_W-1:0];
   assign w_i1 = r_sp[IDX_W-1:0] - IDX_W'(1);
   assign w_i2 = r_sp[IDX_W-1:0] - IDX_W'(2);
   assign w_i3 = r_sp[IDX_W-1:0] - IDX_W'(3);
   assign w_b  = r_stack[w_i1];
   assign w_a  = r_stack[w_i2];
   assign w_c  = r_stack[w_i3];
   assign w_tos_pop1 = (r_sp > SP_W'(1)) ? w_a : {CPU_BIT_WIDTH{1'b0}};
   assign w_tos_pop2 = (r_sp > SP_W'(2)) ? w_c : {CPU_BIT_WIDTH{1'b0}};

   // Depth check: the whole instruction is rejected before any entry moves.
   assign w_pops      = f_pops(w_op);
   assign w_pushes    = f_pushes(w_op);
   assign w_underflow = r_sp < SP_W'(w_pops);
   assign w_after     = SPX_W'(r_sp) + SPX_W'(w_pushes) - SPX_W'(w_pops);
   assign w_overflow  = !w_underflow && (w_after > SPX_W'(STACK_DEPTH));
   assign w_err       = w_underflow || w_overflow;

   assign w_ram_we = ((r_state == ST_EXEC) && (w_op == OP_STORE)) ? 4'hF : 4'h0;

   assign inst_complete = r_complete;
   assign pc_next       = r_pc;
   assign tos           = r_tos;
   assign halted        = r_halted;
   assign error         = r_error;

   ram #(.DEPTH(DMEM_DEPTH), .WIDTH(CPU_BIT_WIDTH)) u_ram (
      .clk  (clk),
      .we   (w_ram_we),
      .addr (w_b),
      .din  (w_a),
      .dout (w_ram_dout)
   );

   // Result of the arithmetic/logic opcodes (a is second, b is top).
   always_comb begin
      w_alu = {CPU_BIT_WIDTH{1'b0}};
      case (w_op)
         OP_ADD:  w_alu = w_a + w_b;
         OP_SUB:  w_alu = w_a - w_b;
         OP_AND:  w_alu = w_a & w_b;
         OP_OR:   w_alu = w_a | w_b;
         OP_XOR:  w_alu = w_a ^ w_b;
         OP_NOT:  w_alu = ~w_b;
         OP_NEG:  w_alu = ~w_b + CPU_BIT_WIDTH'(1);
         default: w_alu = {CPU_BIT_WIDTH{1'b0}};
      endcase
   end

   // Next-state logic; errors and HALT park the machine until reset.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_WAIT: begin
            if (w_accept) w_state_next = ST_DECODE;
            else          w_state_next = ST_WAIT;
         end
         ST_DECODE: begin
            if (w_err || (w_op == OP_HALT)) w_state_next = ST_HALT;
            else                            w_state_next = ST_EXEC;
         end
         ST_EXEC: begin
            if (w_mem_op) w_state_next = ST_MEM;
            else          w_state_next = ST_WAIT;
         end
         ST_MEM:  w_state_next = ST_WAIT;
         ST_HALT: w_state_next = ST_HALT;
         default: w_state_next = ST_WAIT;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_WAIT;
      else     r_state <= w_state_next;
   end

   // Handshake capture, error flags, and retirement (stack, tos, pc) on the last edge of each instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready_d  <= 1'b0;
         r_inst     <= {CPU_BIT_WIDTH{1'b0}};
         r_sp       <= {SP_W{1'b0}};
         r_pc       <= {CPU_BIT_WIDTH{1'b0}};
         r_tos      <= {CPU_BIT_WIDTH{1'b0}};
         r_complete <= 1'b1;
         r_halted   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_ready_d <= inst_ready;
         case (r_state)
            ST_WAIT: begin
               if (w_accept) begin
                  r_inst     <= inst;
                  r_complete <= 1'b0;
               end
            end
            ST_DECODE: begin
               if (w_err) begin
                  r_error  <= 1'b1;
                  r_halted <= 1'b1;
               end else if (w_op == OP_HALT) begin
                  r_halted <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (!w_mem_op) begin
                  r_complete <= 1'b1;
                  r_pc       <= w_pc_inc;
                  case (w_op)
                     OP_PUSH: begin
                        r_stack[w_i0] <= w_imm;
                        r_sp          <= r_sp + SP_W'(1);
                        r_tos         <= w_imm;
                     end
                     OP_POP: begin
                        r_sp  <= r_sp - SP_W'(1);
                        r_tos <= w_tos_pop1;
                     end
                     OP_DUP: begin
                        r_stack[w_i0] <= w_b;
                        r_sp          <= r_sp + SP_W'(1);
                        r_tos         <= w_b;
                     end
                     OP_SWAP: begin
                        r_stack[w_i1] <= w_a;
                        r_stack[w_i2] <= w_b;
                        r_tos         <= w_a;
                     end
                     OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        r_stack[w_i2] <= w_alu;
                        r_sp          <= r_sp - SP_W'(1);
                        r_tos         <= w_alu;
                     end
                     OP_NOT, OP_NEG: begin
                        r_stack[w_i1] <= w_alu;
                        r_tos         <= w_alu;
                     end
                     OP_JMP: begin
                        r_sp  <= r_sp - SP_W'(1);
                        r_tos <= w_tos_pop1;
                        r_pc  <= w_b;
                     end
                     OP_BRZ: begin
                        r_sp  <= r_sp - SP_W'(2);
                        r_tos <= w_tos_pop2;
                        r_pc  <= (w_a == {CPU_BIT_WIDTH{1'b0}}) ? w_b : w_pc_inc;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MEM: begin
               r_complete <= 1'b1;
               r_pc       <= w_pc_inc;
               if (w_op == OP_LOAD) begin
                  r_stack[w_i1] <= w_ram_dout;
                  r_tos         <= w_ram_dout;
               end else begin
                  r_sp  <= r_sp - SP_W'(2);
                  r_tos <= w_tos_pop2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cpu.sv
// Self-checking bench for stack_cpu: directed plan plus randomized programs against a queue-based model.
module tb_stack_cpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'd0;
   logic        inst_ready = 1'b0;
   logic        inst_complete, halted, error;
   logic [31:0] pc_next, tos;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] m_stk [$];
   logic [31:0] m_mem [256];
   logic [31:0] m_pc = 32'd0;
   bit          m_halted = 1'b0, m_err = 1'b0;

   // Expected outputs, refreshed by the driver just after each rising edge.
   bit          exp_valid = 1'b0, exp_complete = 1'b1, exp_halted = 1'b0, exp_err = 1'b0;
   logic [31:0] exp_pc = 32'd0, exp_tos = 32'd0;

   always #5 clk = ~clk;

   stack_cpu dut (
      .clk(clk), .rst(rst), .inst(inst), .inst_ready(inst_ready),
      .inst_complete(inst_complete), .pc_next(pc_next), .tos(tos),
      .halted(halted), .error(error)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model expectation.
   always @(negedge clk) begin
      if (exp_valid) begin
         chk("complete", 32'(inst_complete), 32'(exp_complete));
         chk("pc_next",  pc_next,            exp_pc);
         chk("tos",      tos,                exp_tos);
         chk("halted",   32'(halted),        32'(exp_halted));
         chk("error",    32'(error),         32'(exp_err));
      end
   end

   function automatic logic [31:0] model_tos();
      return (m_stk.size() > 0) ? m_stk[$] : 32'd0;
   endfunction

   // Architectural effect of one instruction; lat=0 means it never retires.
   task automatic model_step(input logic [31:0] w, output int lat);
      logic [4:0]  op;
      logic [31:0] imm, a, b;
      int          need, grow;
      op   = w[31:27];
      imm  = {5'd0, w[26:0]};
      lat  = 0;
      if (m_halted) return;
      case (op)
         5'd2, 5'd3, 5'd6, 5'd11, 5'd14, 5'd16:                need = 1;
         5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13:   need = 2;
         default:                                              need = 0;
      endcase
      grow = (op == 5'd1 || op == 5'd3) ? 1 : 0;
      if (m_stk.size() < need || m_stk.size() + grow > 16) begin
         m_err = 1'b1;
         m_halted = 1'b1;
         return;
      end
      if (op == 5'd15) begin
         m_halted = 1'b1;
         return;
      end
      lat  = (op == 5'd10 || op == 5'd11) ? 4 : 3;
      m_pc = m_pc + 32'd1;
      case (op)
         5'd1:  m_stk.push_back(imm);
         5'd2:  b = m_stk.pop_back();
         5'd3:  m_stk.push_back(m_stk[$]);
         5'd4:  begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(b); m_stk.push_back(a); end
         5'd5:  begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(a + b); end
         5'd7:  begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(a - b); end
         5'd8:  begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(a & b); end
         5'd12: begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(a | b); end
         5'd13: begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(a ^ b); end
         5'd6:  m_pc = m_stk.pop_back();
         5'd9:  begin b = m_stk.pop_back(); a = m_stk.pop_back(); if (a == 32'd0) m_pc = b; end
         5'd10: begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_mem[b[7:0]] = a; end
         5'd11: begin b = m_stk.pop_back(); m_stk.push_back(m_mem[b[7:0]]); end
         5'd14: begin b = m_stk.pop_back(); m_stk.push_back(~b); end
         5'd16: begin b = m_stk.pop_back(); m_stk.push_back(32'd0 - b); end
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      exp_valid  = 1'b0;
      rst        = 1'b1;
      inst_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_stk.delete();
      m_pc = 32'd0; m_halted = 1'b0; m_err = 1'b0;
      exp_complete = 1'b1; exp_pc = 32'd0; exp_tos = 32'd0;
      exp_halted = 1'b0; exp_err = 1'b0; exp_valid = 1'b1;
   endtask

   // Raise inst_ready with w for 'hold' cycles; optionally re-raise it while busy.
   task automatic issue(input logic [31:0] w, input int hold, input bit bounce);
      int          lat, last;
      bit          was_halted;
      logic [31:0] npc, ntos;
      was_halted = m_halted;
      model_step(w, lat);
      npc  = m_pc;
      ntos = model_tos();
      inst = w;
      inst_ready = 1'b1;
      last = ((lat == 0) ? 4 : lat);
      if (hold > last) last = hold;
      last = last + 1;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         if (c >= hold) inst_ready = 1'b0;
         if (bounce && c == 2) inst_ready = 1'b1;
         if (!was_halted) begin
            if (c == 1) exp_complete = 1'b0;
            if (lat != 0 && c == lat) begin
               exp_complete = 1'b1;
               exp_pc = npc;
               exp_tos = ntos;
            end
            if (lat == 0 && c == 2) begin
               exp_halted = m_halted;
               exp_err = m_err;
            end
         end
      end
   endtask

   function automatic logic [31:0] push_w(input logic [26:0] v);
      return {5'd1, v};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

      // Reset state
      do_reset();
      chk("rst_complete", 32'(inst_complete), 32'd1);
      chk("rst_pc",       pc_next,            32'd0);
      chk("rst_tos",      tos,                32'd0);
      chk("rst_flags",    32'({halted, error}), 32'd0);

      // Arithmetic
      issue(32'h0800_0003, 1, 1'b0);
      issue(32'h0800_0004, 1, 1'b1);
      issue(32'h2800_0000, 1, 1'b0);
      chk("add_model", model_tos(), 32'd7);
      chk("add_tos",   tos,         32'd7);
      chk("add_pc",    pc_next,     32'd3);

      // Data memory round trip, subtraction, control flow
      do_reset();
      issue(32'h0800_0007, 1, 1'b0);
      issue(32'h0800_0005, 1, 1'b0);
      issue(32'h5000_0000, 1, 1'b0);
      chk("store_empty", tos, 32'd0);
      issue(32'h0800_0005, 1, 1'b0);
      issue(32'h5800_0000, 1, 1'b0);
      chk("load_tos", tos, 32'd7);
      issue(32'h0800_0001, 1, 1'b0);
      issue(32'h0800_0002, 1, 1'b0);
      issue(32'h3800_0000, 1, 1'b0);
      chk("sub_tos", tos, 32'hFFFF_FFFF);
      issue(32'h0800_001A, 1, 1'b0);
      issue(32'h3000_0000, 1, 1'b0);
      chk("jmp_pc", pc_next, 32'd26);
      issue(32'h0800_0000, 1, 1'b0);
      issue(32'h0800_0009, 1, 1'b0);
      issue(32'h4800_0000, 1, 1'b0);
      chk("brz_taken_pc", pc_next, 32'd9);
      issue(32'h0800_0001, 1, 1'b0);
      issue(32'h0800_0004, 1, 1'b0);
      issue(32'h4800_0000, 1, 1'b0);
      chk("brz_fall_pc",  pc_next, 32'd12);
      chk("brz_fall_tos", tos,     32'hFFFF_FFFF);

      // Underflow
      do_reset();
      issue(32'h1000_0000, 1, 1'b0);
      chk("uflow_flags",    32'({halted, error}), 32'd3);
      chk("uflow_complete", 32'(inst_complete),   32'd0);

      // Overflow on the 17th push
      do_reset();
      for (int i = 0; i < 17; i++) issue(push_w(27'(100 + i)), 1, 1'b0);
      chk("oflow_tos",   tos,        32'd115);
      chk("oflow_error", 32'(error), 32'd1);

      // Held inst_ready executes once; then HALT ignores later requests
      do_reset();
      issue(32'h0800_0001, 10, 1'b0);
      issue(32'h1000_0000, 1, 1'b0);
      chk("held_once_tos", tos,        32'd0);
      chk("held_once_err", 32'(error), 32'd0);
      issue(32'h7800_0000, 1, 1'b0);
      chk("halt_flags", 32'({halted, error}), 32'd2);
      issue(32'h0800_0005, 1, 1'b0);
      chk("halt_ignored_tos",  tos,                32'd0);
      chk("halt_ignored_cmpl", 32'(inst_complete), 32'd0);

      // Fill data memory with known words
      do_reset();
      for (int a = 0; a < 256; a++) begin
         issue(push_w(27'($urandom)), 1, 1'b0);
         issue(push_w(27'(a)), 1, 1'b0);
         issue(32'h5000_0000, 1, 1'b0);
      end

      // Randomized programs; memory survives the resets after HALT/errors
      for (int n = 0; n < 1200; n++) begin
         logic [31:0] w;
         int          r;
         r = $urandom_range(0, 99);
         if (r < 30)      w = push_w(27'($urandom_range(0, 300)));
         else if (r < 40) w = push_w(27'($urandom));
         else             w = {5'($urandom_range(0, 31)), 27'($urandom)};
         issue(w, $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
         if (m_halted) do_reset();
      end

      exp_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
